watch_alarm_core: RTL

Parametrised timekeeping and multi-alarm engine for the Arty-A7 alarm-clock design. It divides the 100 MHz board clock into a 1 Hz tick and keeps BCD hours/minutes/seconds. It compares the time against N programmable alarms and runs a ring/snooze state machine. It feeds the seven-segment scan driver under `top_artyx` and replaces the fixed single-alarm watch logic.

---
 rtl/watch_pkg.sv | 43 ++++
 rtl/watch_alarm_core_bcd_mod_counter.sv | 46 ++++
 rtl/watch_alarm_core.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Purpose : shared types, BCD limits and helpers for the watch/alarm engine.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package watch_pkg;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_e;

    localparam logic [7:0] BCD_MAX_HH = 8'h23;
    localparam logic [7:0] BCD_MAX_MS = 8'h59;

    // Both digits must be decimal and the value must not exceed max. With
    // decimal digits, BCD ordering matches plain binary ordering.
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Converts a valid 24 h BCD hour into {hh12 (BCD 01..12), pm}.
    function automatic logic [8:0] to_12h(input logic [7:0] hh);
        logic [4:0] h;
        logic [4:0] h12;
        logic [4:0] ones;
        logic       pm_f;
        h    = {1'b0, hh[7:4]} * 5'd10 + {1'b0, hh[3:0]};
        pm_f = (h >= 5'd12);
        h12  = pm_f ? (h - 5'd12) : h;
        if (h12 == 5'd0) begin
            h12 = 5'd12;
        end
        ones = (h12 >= 5'd10) ? (h12 - 5'd10) : h12;
        return {3'd0, (h12 >= 5'd10), ones[3:0], pm_f};
    endfunction

endpackage

// File: rtl/watch_alarm_core_bcd_mod_counter.sv
// Purpose : two-digit BCD counter wrapping from max_i to 00, with carry out.
// Latency : q_o updates on the edge that samples inc_i/load_i.
// Backpr. : none; load_i has priority over inc_i.
// Ports   : clk_i, rst_i (sync active-high), inc_i, load_i, load_val_i,
//           max_i (BCD wrap value), q_o (BCD count), carry_o (wrap this cycle).
module bcd_mod_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] max_i,
    output logic [7:0] q_o,
    output logic       carry_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (inc_i) begin
            if (q_q == max_i) begin
                q_d = 8'h00;
            end else if (q_q[3:0] == 4'd9) begin
                q_d = {q_q[7:4] + 4'd1, 4'd0};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = inc_i && !load_i && (q_q == max_i);

endmodule

// File: rtl/watch_alarm_core.sv
// Purpose : 1 Hz prescaler, BCD hh:mm:ss clock, N alarm channels and a
//           ring/snooze FSM driving the display and buzzer logic.
// Latency : cur_time 1 cycle after tick/valid load; ring 1 cycle after the
//           matching time is shown; load_err 1 cycle after a bad write.
// Backpr. : none; all inputs are single-cycle pulses, all outputs registered.
// Ports   : CLK100MHZ, BTNC (sync active-high reset), time_we/time_in,
//           alm_we/alm_idx/alm_time/alm_en_in, dismiss, snooze ->
//           tick_1hz, cur_time, pm, ring, ring_id, load_err.
module watch_alarm_core
    import watch_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter bit MODE_12H   = 1'b0,
    localparam int AW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic          CLK100MHZ,
    input  logic          BTNC,
    input  logic          time_we,
    input  logic [23:0]   time_in,
    input  logic          alm_we,
    input  logic [AW-1:0] alm_idx,
    input  logic [15:0]   alm_time,
    input  logic          alm_en_in,
    input  logic          dismiss,
    input  logic          snooze,
    output logic          tick_1hz,
    output logic [23:0]   cur_time,
    output logic          pm,
    output logic          ring,
    output logic [AW-1:0] ring_id,
    output logic          load_err
);

    localparam int PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SNZ_SEC = SNOOZE_MIN * 60;
    localparam int CNT_MAX = (RING_SEC > SNZ_SEC) ? RING_SEC : SNZ_SEC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] RING_LD    = CW'(RING_SEC);
    localparam logic [CW-1:0] SNZ_LD     = CW'(SNZ_SEC);

    // ---------------- write validation ----------------
    logic              time_ok;
    logic              time_load;
    logic              alm_ok;
    logic [(1<<AW)-1:0] idx_legal;

    genvar gi;
    generate
        for (gi = 0; gi < (1 << AW); gi++) begin : g_idx
            assign idx_legal[gi] = (gi < N_ALARMS);
        end
    endgenerate

    assign time_ok   = bcd_valid(time_in[23:16], BCD_MAX_HH)
                    && bcd_valid(time_in[15:8],  BCD_MAX_MS)
                    && bcd_valid(time_in[7:0],   BCD_MAX_MS);
    assign time_load = time_we && time_ok;
    assign alm_ok    = idx_legal[alm_idx]
                    && bcd_valid(alm_time[15:8], BCD_MAX_HH)
                    && bcd_valid(alm_time[7:0],  BCD_MAX_MS);

    // ---------------- prescaler ----------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_q;
    logic          tick_upd_q;   // counters were advanced by a tick last edge
    logic          load_err_q;

    always_comb begin
        if (time_load || tick_q) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            tick_upd_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            // tick_q is high exactly while the prescaler sits at its last count
            tick_q     <= (presc_d == PRESC_LAST);
            // a load in the same cycle swallows the tick, so no match follows
            tick_upd_q <= tick_q && !time_load;
            load_err_q <= (time_we && !time_ok) || (alm_we && !alm_ok);
        end
    end

    // ---------------- BCD time counters ----------------
    logic [7:0] ss_q;
    logic [7:0] mm_q;
    logic [7:0] hh_q;
    logic       carry_ss;
    logic       carry_mm;
    logic       day_wrap_unused;

    bcd_mod_counter u_ss (
        .clk_i      (CLK100MHZ),
        .rst_i      (BTNC),
        .inc_i      (tick_q && !time_load),
        .load_i     (time_load),
        .load_val_i (time_in[7:0]),
        .max_i      (BCD_MAX_MS),
        .q_o        (ss_q),
        .carry_o    (carry_ss)
    );

    bcd_mod_counter u_mm (
        .clk_i      (CLK100MHZ),
        .rst_i      (BTNC),
        .inc_i      (carry_ss),
        .load_i     (time_load),
        .load_val_i (time_in[15:8]),
        .max_i      (BCD_MAX_MS),
        .q_o        (mm_q),
        .carry_o    (carry_mm)
    );

    bcd_mod_counter u_hh (
        .clk_i      (CLK100MHZ),
        .rst_i      (BTNC),
        .inc_i      (carry_mm),
        .load_i     (time_load),
        .load_val_i (time_in[23:16]),
        .max_i      (BCD_MAX_HH),
        .q_o        (hh_q),
        .carry_o    (day_wrap_unused)
    );

    // ---------------- alarm registers ----------------
    logic [15:0]         alm_time_q [N_ALARMS];
    logic [N_ALARMS-1:0] alm_en_q;

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                alm_time_q[i] <= 16'h0000;
            end
            alm_en_q <= '0;
        end else if (alm_we && alm_ok) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (alm_idx == AW'(i)) begin
                    alm_time_q[i] <= alm_time;
                    alm_en_q[i]   <= alm_en_in;
                end
            end
        end
    end

    // Match is checked one cycle after a tick, against the freshly advanced
    // time. Scanning downwards lets the lowest matching index win.
    logic          match_vld;
    logic [AW-1:0] match_id;

    always_comb begin
        match_vld = 1'b0;
        match_id  = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (tick_upd_q && (ss_q == 8'h00) && alm_en_q[i]
                && (alm_time_q[i] == {hh_q, mm_q})) begin
                match_vld = 1'b1;
                match_id  = AW'(i);
            end
        end
    end

    // ---------------- ring / snooze FSM ----------------
    alarm_state_e  state_q;
    alarm_state_e  state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [AW-1:0] id_q;
    logic [AW-1:0] id_d;
    logic          ring_q;
    logic          ring_d;

    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            ring_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ring_q  <= ring_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (match_vld) begin
                    state_d = RING;
                    cnt_d   = RING_LD;
                    id_d    = match_id;
                end
            end
            RING: begin
                if (dismiss) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (snooze) begin
                    state_d = SNOOZE;
                    cnt_d   = SNZ_LD;
                end else if (tick_q) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            SNOOZE: begin
                if (dismiss) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (match_vld) begin
                    state_d = RING;
                    cnt_d   = RING_LD;
                    id_d    = match_id;
                end else if (tick_q) begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = RING;
                        cnt_d   = RING_LD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ring_d = (state_d == RING);
    end

    // ---------------- outputs ----------------
    logic [8:0] h12;
    assign h12 = to_12h(hh_q);

    assign tick_1hz = tick_q;
    assign cur_time = MODE_12H ? {h12[8:1], mm_q, ss_q} : {hh_q, mm_q, ss_q};
    assign pm       = MODE_12H ? h12[0] : 1'b0;
    assign ring     = ring_q;
    assign ring_id  = id_q;
    assign load_err = load_err_q;

endmodule
